// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with
// a double-buffered display word, anti-ghosting blank window and zero suppression.

module hex_decoder (
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);
  // Active-low segments {g,f,e,d,c,b,a}
  always_comb begin
    seg_c = 7'h7F;
    unique case (nib)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = 7'h7F;
    endcase
  end
endmodule

module seg7_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    upd_ack,
  output logic                    pending
);
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [VAL_W-1:0]      disp_val_q, disp_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0] disp_blank_q, disp_blank_d, pend_blank_q, pend_blank_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
  logic                  pending_q, pending_d, upd_ack_q, upd_ack_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic                  slot_end, frame_end, commit;
  logic [3:0]            dig_nib;
  logic                  dig_blank, dig_dp, lz_dark, zero_run;
  logic [6:0]            hex_seg_c;

  // Slot/digit counters and the pending -> display commit at frame end
  always_comb begin
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    disp_val_d   = disp_val_q;
    disp_blank_d = disp_blank_q;
    disp_dp_d    = disp_dp_q;
    pend_val_d   = pend_val_q;
    pend_blank_d = pend_blank_q;
    pend_dp_d    = pend_dp_q;
    pending_d    = pending_q;

    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);
    commit    = frame_end && pending_q;
    upd_ack_d = commit;

    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (commit) begin
      disp_val_d   = pend_val_q;
      disp_blank_d = pend_blank_q;
      disp_dp_d    = pend_dp_q;
      pending_d    = 1'b0;
    end
    // A load coinciding with a commit lands in the pending buffer for the next frame
    if (load) begin
      pend_val_d   = value;
      pend_blank_d = blank_mask;
      pend_dp_d    = dp_mask;
      pending_d    = 1'b1;
    end
  end

  // Select the active digit; scanning from the top tracks the all-zero run above it
  always_comb begin
    dig_nib   = 4'h0;
    dig_blank = 1'b0;
    dig_dp    = 1'b0;
    lz_dark   = 1'b0;
    zero_run  = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp_val_q[4*k +: 4] == 4'h0);
      if (idx_q == IDX_W'(k)) begin
        dig_nib   = disp_val_q[4*k +: 4];
        dig_blank = disp_blank_q[k];
        dig_dp    = disp_dp_q[k];
        lz_dark   = zero_run && (k != 0);
      end
    end
  end

  hex_decoder u_hex (
    .nib   (dig_nib),
    .seg_c (hex_seg_c)
  );

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (cnt_q >= CNT_BLANK) begin
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        an_d[k] = (idx_q != IDX_W'(k));
      end
      if (!(dig_blank || (lz_en && lz_dark))) begin
        seg_d = hex_seg_c;
        dp_d  = ~dig_dp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_blank_q <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_blank_q <= '0;
      pend_dp_q    <= '0;
      pending_q    <= 1'b0;
      upd_ack_q    <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_blank_q <= disp_blank_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_blank_q <= pend_blank_d;
      pend_dp_q    <= pend_dp_d;
      pending_q    <= pending_d;
      upd_ack_q    <= upd_ack_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign upd_ack = upd_ack_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller (4 digits, 4-cycle slots, 1 blank cycle)
// with a per-cycle expected-output scoreboard.

module tb_seg7_scan_controller;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst, load, lz_en;
  logic [15:0] value;
  logic [3:0]  blank_mask, dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp, upd_ack, pending;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       upd_ack;
    logic       pending;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int          m_cnt, m_idx;
  logic [15:0] m_val, m_pval;
  logic [3:0]  m_blk, m_pblk, m_dp, m_pdp;
  logic        m_pend;

  seg7_scan_controller #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .lz_en      (lz_en),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .upd_ack    (upd_ack),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance the model on the same edge the DUT samples; push what the DUT should show after it
  task automatic model_tick();
    exp_t        e;
    logic [3:0]  nib;
    logic        dark, fe;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_pend = 1'b0;
      m_val = '0; m_blk = '0; m_dp = '0; m_pval = '0; m_pblk = '0; m_pdp = '0;
      e = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};
    end else begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
      if (m_cnt >= BC) begin
        e.an = ~(4'b0001 << m_idx);
        nib  = 4'(m_val >> (4 * m_idx));
        dark = m_blk[m_idx] || (lz_en && (m_idx > 0) && ((m_val >> (4 * m_idx)) == 16'h0));
        if (!dark) begin
          e.seg = hex7(nib);
          e.dp  = ~m_dp[m_idx];
        end
      end
      fe        = (m_cnt == RD - 1) && (m_idx == ND - 1);
      e.upd_ack = fe && m_pend;
      if (e.upd_ack) begin
        m_val = m_pval; m_blk = m_pblk; m_dp = m_pdp; m_pend = 1'b0;
      end
      if (load) begin
        m_pval = value; m_pblk = blank_mask; m_pdp = dp_mask; m_pend = 1'b1;
      end
      e.pending = m_pend;
      if (m_cnt == RD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % ND;
      end else begin
        m_cnt++;
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    model_tick();
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("scoreboard {an,seg,dp,ack,pend}", 32'({an, seg, dp, upd_ack, pending}), 32'(e));
    end
  endtask

  task automatic wait_an(input logic [3:0] target);
    int n = 0;
    while (an !== target && n < 40) begin
      step();
      n++;
    end
    chk("wait_an", 32'(an), 32'(target));
  endtask

  task automatic wait_ack();
    int n = 0;
    while (upd_ack !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("wait_ack", 32'(upd_ack), 32'd1);
  endtask

  // One full frame: each lit digit must show its expected pattern and decimal point
  task automatic check_frame(input string tag, input logic [27:0] segs, input logic [3:0] dpn);
    repeat (ND * RD) begin
      step();
      if (an === 4'hF) begin
        chk({tag, "_blank_seg"}, 32'(seg), 32'h7F);
      end else begin
        for (int k = 0; k < ND; k++) begin
          if (an[k] === 1'b0) begin
            chk({tag, "_seg"}, 32'(seg), 32'(segs[k*7 +: 7]));
            chk({tag, "_dp"}, 32'(dp), 32'(dpn[k]));
          end
        end
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] b, input logic [3:0] d);
    value = v; blank_mask = b; dp_mask = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int acks;
    rst = 1'b1; load = 1'b0; lz_en = 1'b0;
    value = '0; blank_mask = '0; dp_mask = '0;

    // Reset state
    step(); step();
    chk("reset_outputs", 32'({an, seg, dp, upd_ack, pending}), 32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}));
    rst = 1'b0;

    // Free-running scan of an all-zero word
    step();
    chk("t1_blank_an", 32'(an), 32'hF);
    repeat (3) begin
      step();
      chk("t1_d0_an", 32'(an), 32'hE);
      chk("t1_d0_seg", 32'(seg), 32'h40);
    end
    step();
    chk("t1_gap_an", 32'(an), 32'hF);
    step();
    chk("t1_d1_an", 32'(an), 32'hD);

    // Mid-frame load is held until frame end
    wait_an(4'b1101);
    do_load(16'h12AF, 4'h0, 4'h0);
    chk("t2_pending", 32'(pending), 32'd1);
    chk("t2_no_ack", 32'(upd_ack), 32'd0);
    wait_ack();
    chk("t2_pending_clr", 32'(pending), 32'd0);
    check_frame("t2", {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF);

    // Two loads in one frame: latest wins, single ack
    wait_an(4'b1101);
    do_load(16'h1111, 4'h0, 4'h0);
    do_load(16'h2222, 4'h0, 4'h0);
    acks = 0;
    repeat (40) begin
      step();
      if (upd_ack === 1'b1) acks++;
    end
    chk("t3_ack_count", 32'(acks), 32'd1);
    check_frame("t3", {7'h24, 7'h24, 7'h24, 7'h24}, 4'hF);

    // Leading-zero suppression
    lz_en = 1'b1;
    wait_an(4'b1101);
    do_load(16'h0050, 4'h0, 4'h0);
    wait_ack();
    check_frame("t4a", {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF);
    do_load(16'h0000, 4'h0, 4'h0);
    wait_ack();
    check_frame("t4b", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF);

    // Blank mask and decimal point
    lz_en = 1'b0;
    do_load(16'h1234, 4'b0100, 4'b0001);
    wait_ack();
    check_frame("t5", {7'h79, 7'h7F, 7'h30, 7'h19}, 4'b1110);

    // Load on the exact commit edge: old pending commits, new one stays pending
    wait_an(4'b1101);
    do_load(16'h3333, 4'h0, 4'h0);
    wait_an(4'b0111);
    step();
    do_load(16'h4444, 4'h0, 4'h0);
    chk("t6_ack", 32'(upd_ack), 32'd1);
    chk("t6_pending_kept", 32'(pending), 32'd1);
    check_frame("t6a", {7'h30, 7'h30, 7'h30, 7'h30}, 4'hF);
    wait_ack();
    check_frame("t6b", {7'h19, 7'h19, 7'h19, 7'h19}, 4'hF);

    // Asynchronous reset mid-slot discards pending data
    wait_an(4'b1101);
    do_load(16'h5555, 4'h0, 4'h0);
    chk("t7_pending", 32'(pending), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_async_reset", 32'({an, seg, dp, upd_ack, pending}), 32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}));
    step();
    rst = 1'b0;
    step();
    chk("t7_restart_blank", 32'(an), 32'hF);
    chk("t7_pending_lost", 32'(pending), 32'd0);
    step();
    chk("t7_restart_d0", 32'(an), 32'hE);
    check_frame("t7", {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
